img_frame_scanner_mem: RTL and testbench

// - Parametrised dual-port image buffer for the 2D DWT datapath. Port A is a

---
 rtl/img_frame_scanner_mem.sv | 251 +++++++++++++++++++++++++
 tb/tb_img_frame_scanner_mem.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_scanner_mem.sv
`default_nettype none
// ============================================================================
// Module      : img_frame_scanner_mem
// Description : Dual-port image buffer for the 2D DWT datapath.
//               Port A is a streaming scan engine that walks a runtime
//               sub-image anchored at (0,0), in row-major or column-major
//               order, onto an AXI-style stream.
//               Port B is a read-first random-access port that the DWT core
//               uses for coefficient write-back.
// Options     : IMG_FB_BYPASS_EN - when defined, a port B write to the word
//               the scanner reads in the same cycle is forwarded to the
//               scanner. Port B itself remains read-first.
// Revision    : 1.0 - initial release
// ============================================================================
module img_frame_scanner_mem #(
  parameter int DATA_W = 8,
  parameter int HEIGHT = 256,
  parameter int WIDTH  = 256,
  parameter int AW     = $clog2(HEIGHT*WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  // scan control
  input  logic                         start,
  input  logic                         col_mode,
  input  logic [$clog2(HEIGHT+1)-1:0]  scan_h,
  input  logic [$clog2(WIDTH+1)-1:0]   scan_w,
  output logic                         busy,
  output logic                         done,
  // scan stream
  output logic                         s_valid,
  input  logic                         s_ready,
  output logic [DATA_W-1:0]            s_data,
  output logic                         s_eol,
  output logic                         s_last,
  // random-access port
  input  logic                         en_b,
  input  logic                         we_b,
  input  logic [AW-1:0]                addr_b,
  input  logic [DATA_W-1:0]            din_b,
  output logic [DATA_W-1:0]            dout_b
);

  localparam int c_HW    = $clog2(HEIGHT+1);
  localparam int c_WW    = $clog2(WIDTH+1);
  localparam int c_DEPTH = HEIGHT*WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Storage (never reset)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [c_DEPTH];

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_cm;
  logic [c_HW-1:0]   r_h;
  logic [c_WW-1:0]   r_w;
  logic [c_HW-1:0]   r_row;
  logic [c_WW-1:0]   r_col;

  // Output buffer: r_ram_* receives every RAM read, r_skid_* holds the
  // older beat when a read lands while the head beat is stalled.
  logic [DATA_W-1:0] r_ram_q;
  logic              r_ram_eol;
  logic              r_ram_last;
  logic              r_ram_vld;
  logic [DATA_W-1:0] r_skid;
  logic              r_skid_eol;
  logic              r_skid_last;
  logic              r_skid_vld;

  logic [DATA_W-1:0] r_dout_b;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [c_HW-1:0]   w_h_sat;
  logic [c_WW-1:0]   w_w_sat;
  logic              w_row_last;
  logic              w_col_last;
  logic              w_eol;
  logic              w_last;
  logic              w_issue;
  logic              w_accept;
  logic              w_head_last;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_word;

  // Oversized requests clamp to the physical image.
  assign w_h_sat = (scan_h > c_HW'(HEIGHT)) ? c_HW'(HEIGHT) : scan_h;
  assign w_w_sat = (scan_w > c_WW'(WIDTH))  ? c_WW'(WIDTH)  : scan_w;

  assign w_row_last = (r_row == (r_h - c_HW'(1)));
  assign w_col_last = (r_col == (r_w - c_WW'(1)));
  assign w_eol      = r_cm ? w_row_last : w_col_last;
  assign w_last     = w_row_last & w_col_last;

  // A read is issued only when the read can land in a free buffer slot.
  assign w_issue  = (r_state == S_SCAN) && !(r_ram_vld && r_skid_vld);
  assign s_valid  = r_ram_vld | r_skid_vld;
  assign w_accept = s_valid & s_ready;

  // The skid entry is always the older beat, so it is the head when valid.
  assign s_data      = r_skid_vld ? r_skid      : r_ram_q;
  assign s_eol       = r_skid_vld ? r_skid_eol  : r_ram_eol;
  assign s_last      = r_skid_vld ? r_skid_last : r_ram_last;
  assign w_head_last = s_last;

  assign w_rd_addr = (AW'(r_row) * AW'(WIDTH)) + AW'(r_col);

`ifdef IMG_FB_BYPASS_EN
  // Same-cycle write to the word being scanned is forwarded to the scanner.
  assign w_rd_word = (en_b && we_b && (addr_b == w_rd_addr)) ? din_b
                                                             : r_mem[w_rd_addr];
`else
  // Scanner observes the pre-write contents on a same-address collision.
  assign w_rd_word = r_mem[w_rd_addr];
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign dout_b = r_dout_b;

  // --------------------------------------------------------------------------
  // Port B write into the storage array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (en_b && we_b) begin
      r_mem[addr_b] <= din_b;
    end
  end

  // Port B read-first data register; holds while the port is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_b <= '0;
    end else if (en_b) begin
      r_dout_b <= r_mem[addr_b];
    end
  end

  // Scan FSM: accepts start, walks the address counters, signals completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cm    <= 1'b0;
      r_h     <= '0;
      r_w     <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cm  <= col_mode;
            r_h   <= w_h_sat;
            r_w   <= w_w_sat;
            r_row <= '0;
            r_col <= '0;
            // An empty sub-image completes immediately without streaming.
            if ((w_h_sat == '0) || (w_w_sat == '0)) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            if (w_last) begin
              r_state <= S_DRAIN;
            end else if (r_cm) begin
              if (w_row_last) begin
                r_row <= '0;
                r_col <= r_col + c_WW'(1);
              end else begin
                r_row <= r_row + c_HW'(1);
              end
            end else begin
              if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + c_HW'(1);
              end else begin
                r_col <= r_col + c_WW'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_accept && w_head_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer fed by scanner reads, drained by the stream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_q     <= '0;
      r_ram_eol   <= 1'b0;
      r_ram_last  <= 1'b0;
      r_ram_vld   <= 1'b0;
      r_skid      <= '0;
      r_skid_eol  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_vld  <= 1'b0;
    end else if (w_issue) begin
      // Only reachable with at most one beat buffered (in r_ram_*).
      if (r_ram_vld && !w_accept) begin
        r_skid      <= r_ram_q;
        r_skid_eol  <= r_ram_eol;
        r_skid_last <= r_ram_last;
        r_skid_vld  <= 1'b1;
      end
      r_ram_q    <= w_rd_word;
      r_ram_eol  <= w_eol;
      r_ram_last <= w_last;
      r_ram_vld  <= 1'b1;
    end else if (w_accept) begin
      if (r_skid_vld) begin
        r_skid_vld <= 1'b0;
      end else begin
        r_ram_vld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_frame_scanner_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_frame_scanner_mem
// Description : Scoreboard bench for img_frame_scanner_mem. Expected beats are
//               queued from a byte model of the image when a scan starts and
//               compared as the stream delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_frame_scanner_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        col_mode;
  logic [8:0]  scan_h;
  logic [8:0]  scan_w;
  logic        busy;
  logic        done;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_eol;
  logic        s_last;
  logic        en_b;
  logic        we_b;
  logic [15:0] addr_b;
  logic [7:0]  din_b;
  logic [7:0]  dout_b;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       last;
  } beat_t;

  beat_t      sbq[$];
  logic [7:0] tb_mem [0:2047];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   rk = 0;
  bit   done_seen = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_cyc = -1;
  int   first_vld_cyc = -1;
  int   start_cyc = 0;
  bit   stalled_prev = 0;
  logic [9:0] prev_beat = '0;

  img_frame_scanner_mem #(
    .DATA_W (8),
    .HEIGHT (256),
    .WIDTH  (256)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .col_mode (col_mode),
    .scan_h   (scan_h),
    .scan_w   (scan_w),
    .busy     (busy),
    .done     (done),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_eol    (s_eol),
    .s_last   (s_last),
    .en_b     (en_b),
    .we_b     (we_b),
    .addr_b   (addr_b),
    .din_b    (din_b),
    .dout_b   (dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Downstream ready: constant high, or the 1,0,0 repeating pattern.
  initial begin
    s_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_ready = (rdy_mode == 0) ? 1'b1 : ((rk % 3) == 0);
      rk++;
    end
  end

  // Stream monitor: scoreboard pops, stall stability, done bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled_prev) begin
        check("hold_valid", 32'(s_valid), 32'd1);
        check("hold_beat", 32'({s_data, s_eol, s_last}), 32'(prev_beat));
      end
      stalled_prev = s_valid && !s_ready;
      prev_beat    = {s_data, s_eol, s_last};
      if (s_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (s_valid && s_ready) begin
        if (sbq.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = sbq.pop_front();
          check("beat_data", 32'(s_data), 32'(e.d));
          check("beat_eol",  32'(s_eol),  32'(e.eol));
          check("beat_last", 32'(s_last), 32'(e.last));
        end
        if (s_last) last_cyc = cyc;
      end
      if (done) begin
        done_seen = 1;
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      stalled_prev = 0;
    end
  end

  task automatic push_scan(input bit cm, input int h, input int w);
    beat_t b;
    if (!cm) begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          b.d = tb_mem[r*256 + c]; b.eol = (c == w-1); b.last = (r == h-1) && (c == w-1);
          sbq.push_back(b);
        end
    end else begin
      for (int c = 0; c < w; c++)
        for (int r = 0; r < h; r++) begin
          b.d = tb_mem[r*256 + c]; b.eol = (r == h-1); b.last = (r == h-1) && (c == w-1);
          sbq.push_back(b);
        end
    end
  endtask

  task automatic start_scan(input bit cm, input int h, input int w);
    done_seen     = 0;
    first_vld_cyc = -1;
    last_cyc      = -1;
    @(posedge clk);
    #1;
    col_mode  = cm;
    scan_h    = 9'(h);
    scan_w    = 9'(w);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done_seen && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_seen), 32'd1);
    if (done_seen) check("done_after_last", done_cyc, last_cyc + 1);
    check("busy_off", 32'(busy), 32'd0);
    check("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    int base;
    beat_t b;
    rst = 1'b1; start = 1'b0; col_mode = 1'b0; scan_h = '0; scan_w = '0;
    en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_valid",   32'(s_valid), 32'd0);
    check("rst_eol",     32'(s_eol),   32'd0);
    check("rst_last",    32'(s_last),  32'd0);
    check("rst_data",    32'(s_data),  32'd0);
    check("rst_dout_b",  32'(dout_b),  32'd0);
    rst = 1'b0;

    // Fill mem[i] = i[7:0] over the region the scans touch.
    for (int i = 0; i < 2048; i++) begin
      @(posedge clk);
      #1;
      en_b = 1'b1; we_b = 1'b1; addr_b = 16'(i); din_b = 8'(i);
      tb_mem[i] = 8'(i);
    end
    @(posedge clk);
    #1;
    en_b = 1'b1; we_b = 1'b0; addr_b = 16'd261;
    @(posedge clk);
    #1;
    en_b = 1'b0; addr_b = 16'd9;
    check("portb_read", 32'(dout_b), 32'h05);
    @(posedge clk);
    #1;
    check("portb_hold", 32'(dout_b), 32'h05);

    // Row-major 4x4 at full rate.
    push_scan(0, 4, 4);
    start_scan(0, 4, 4);
    check("busy_on", 32'(busy), 32'd1);
    wait_done(200);
    check("first_latency", first_vld_cyc, start_cyc + 2);

    // Column-major 4x4 at full rate.
    push_scan(1, 4, 4);
    start_scan(1, 4, 4);
    wait_done(200);
    check("first_latency_col", first_vld_cyc, start_cyc + 2);

    // Row-major 2x8 with back-pressure.
    rdy_mode = 1;
    push_scan(0, 2, 8);
    start_scan(0, 2, 8);
    wait_done(400);
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Collision on address 1 in a 2x2 row-major scan.
    push_scan(0, 2, 2);
    b = sbq[1];
`ifdef IMG_FB_BYPASS_EN
    b.d = 8'hAA;
`else
    b.d = 8'h01;
`endif
    sbq[1] = b;
    start_scan(0, 2, 2);
    @(posedge clk);
    #1;
    en_b = 1'b1; we_b = 1'b1; addr_b = 16'd1; din_b = 8'hAA;
    @(posedge clk);
    #1;
    en_b = 1'b0; we_b = 1'b0;
    check("collision_dout_b", 32'(dout_b), 32'h01);
    tb_mem[1] = 8'hAA;
    wait_done(200);

    // Reset during beat 5 of an 8x8 scan aborts without done.
    push_scan(0, 8, 8);
    start_scan(0, 8, 8);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid", 32'(s_valid), 32'd0);
    check("abort_busy",  32'(busy),    32'd0);
    rst = 1'b0;
    sbq.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Fresh scan after the abort restarts at the origin.
    push_scan(0, 2, 2);
    start_scan(0, 2, 2);
    wait_done(200);

    // A start while busy is ignored.
    base = done_cnt;
    push_scan(0, 4, 4);
    start_scan(0, 4, 4);
    repeat (3) @(posedge clk);
    #1;
    col_mode = 1'b1; scan_h = 9'd2; scan_w = 9'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);
    repeat (6) @(posedge clk);
    #1;
    check("single_done", done_cnt - base, 1);
    check("no_restart_valid", 32'(s_valid), 32'd0);

    // Empty sub-image: done only.
    start_scan(0, 4, 0);
    check("zero_done",  32'(done),  32'd1);
    check("zero_busy",  32'(busy),  32'd0);
    @(posedge clk);
    #1;
    check("zero_done_pulse", 32'(done),    32'd0);
    check("zero_no_beat",    32'(s_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
